// File: rtl/baccarat_pkg.sv
// Shared baccarat types and helpers: card encoding and card-to-value mapping.
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_KING  = 4'd13;

    // Baccarat point value: A..9 count face value, 10/J/Q/K and empty count 0.
    function automatic logic [3:0] card_value(input card_t c);
        if (c >= 4'd1 && c <= 4'd9)
            return c;
        else
            return 4'd0;
    endfunction

endpackage

// File: rtl/hand_score.sv
// Combinational hand score: sum of three card values modulo 10.
module hand_score
    import baccarat_pkg::*;
(
    input  card_t       card1,
    input  card_t       card2,
    input  card_t       card3,
    output logic [3:0]  score
);

    logic [4:0] sum;
    logic [4:0] sum_mod;

    // Max sum is 27, so 5 bits hold it without overflow.
    always_comb begin
        sum     = {1'b0, card_value(card1)} + {1'b0, card_value(card2)}
                + {1'b0, card_value(card3)};
        sum_mod = sum % 5'd10;
        score   = sum_mod[3:0];
    end

endmodule

// File: rtl/hand_datapath.sv
// Card-holding datapath: six card registers, two hand scorers and
// saturating win/loss/tie tallies sampled once per completed round.
module hand_datapath
    import baccarat_pkg::*;
#(
    parameter int TALLY_W = 8
) (
    input  logic               slow_clock,
    input  logic               reset,
    input  logic [3:0]         new_card,
    input  logic               load_pcard1,
    input  logic               load_pcard2,
    input  logic               load_pcard3,
    input  logic               load_dcard1,
    input  logic               load_dcard2,
    input  logic               load_dcard3,
    input  logic               new_round,
    input  logic               player_win_light,
    input  logic               dealer_win_light,
    output logic [3:0]         pcard1,
    output logic [3:0]         pcard2,
    output logic [3:0]         pcard3,
    output logic [3:0]         dcard1,
    output logic [3:0]         dcard2,
    output logic [3:0]         dcard3,
    output logic [3:0]         pscore,
    output logic [3:0]         dscore,
    output logic [TALLY_W-1:0] player_tally,
    output logic [TALLY_W-1:0] dealer_tally,
    output logic [TALLY_W-1:0] tie_tally
);

    localparam logic [TALLY_W-1:0] TALLY_ONE = {{(TALLY_W-1){1'b0}}, 1'b1};
    localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

    // Index order: player 1..3, then dealer 1..3.
    card_t      card_q [6];
    card_t      card_d [6];
    logic [5:0] load;
    card_t      card_in;

    logic [1:0]         lights;
    logic [1:0]         prev_result_q, prev_result_d;
    logic               round_done;
    logic [TALLY_W-1:0] player_q, player_d;
    logic [TALLY_W-1:0] dealer_q, dealer_d;
    logic [TALLY_W-1:0] tie_q, tie_d;

    assign load   = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};
    assign lights = {player_win_light, dealer_win_light};

    // Sanitize the incoming card; out-of-range codes are stored as empty.
    always_comb begin
        card_in = CARD_EMPTY;
        if (new_card >= 4'd1 && new_card <= CARD_KING)
            card_in = new_card;
    end

    // Next card state: new_round clears everything and beats any load.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            card_d[i] = card_q[i];
            if (new_round)
                card_d[i] = CARD_EMPTY;
            else if (load[i])
                card_d[i] = card_in;
        end
    end

    // Card register bank.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) card_q[i] <= CARD_EMPTY;
        end else begin
            for (int i = 0; i < 6; i++) card_q[i] <= card_d[i];
        end
    end

    // Round completion on the 00 -> non-zero light transition; saturating counts.
    always_comb begin
        round_done    = (prev_result_q == 2'b00) && (lights != 2'b00);
        prev_result_d = new_round ? 2'b00 : lights;
        player_d      = player_q;
        dealer_d      = dealer_q;
        tie_d         = tie_q;
        if (round_done) begin
            case (lights)
                2'b10:   if (player_q != TALLY_MAX) player_d = player_q + TALLY_ONE;
                2'b01:   if (dealer_q != TALLY_MAX) dealer_d = dealer_q + TALLY_ONE;
                2'b11:   if (tie_q    != TALLY_MAX) tie_d    = tie_q    + TALLY_ONE;
                default: ;
            endcase
        end
    end

    // Edge detector and tally registers.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            prev_result_q <= 2'b00;
            player_q      <= '0;
            dealer_q      <= '0;
            tie_q         <= '0;
        end else begin
            prev_result_q <= prev_result_d;
            player_q      <= player_d;
            dealer_q      <= dealer_d;
            tie_q         <= tie_d;
        end
    end

    hand_score u_pscore (
        .card1 (card_q[0]),
        .card2 (card_q[1]),
        .card3 (card_q[2]),
        .score (pscore)
    );

    hand_score u_dscore (
        .card1 (card_q[3]),
        .card2 (card_q[4]),
        .card3 (card_q[5]),
        .score (dscore)
    );

    assign pcard1       = card_q[0];
    assign pcard2       = card_q[1];
    assign pcard3       = card_q[2];
    assign dcard1       = card_q[3];
    assign dcard2       = card_q[4];
    assign dcard3       = card_q[5];
    assign player_tally = player_q;
    assign dealer_tally = dealer_q;
    assign tie_tally    = tie_q;

endmodule

// File: tb/tb_hand_datapath.sv
// Bench for hand_datapath: directed plan steps plus random traffic, checked
// against an arithmetic model. A second instance with 2-bit tallies shares
// the stimulus to exercise saturation.
module tb_hand_datapath;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] nc = 4'd0;
    logic [5:0] ld = 6'd0;
    logic       nr = 1'b0;
    logic       pw = 1'b0;
    logic       dw = 1'b0;

    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3, ps, ds;
    logic [7:0] pt, dt, tt;
    logic [3:0] s_pc1, s_pc2, s_pc3, s_dc1, s_dc2, s_dc3, s_ps, s_ds;
    logic [1:0] s_pt, s_dt, s_tt;

    int errors = 0;
    int checks = 0;

    // Model state
    int m_card [6];
    int m_pt, m_dt, m_tt;
    int s_mpt, s_mdt, s_mtt;
    int m_prev;

    always #5 clk = ~clk;

    hand_datapath #(.TALLY_W(8)) dut (
        .slow_clock(clk), .reset(rst), .new_card(nc),
        .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
        .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
        .new_round(nr), .player_win_light(pw), .dealer_win_light(dw),
        .pcard1(pc1), .pcard2(pc2), .pcard3(pc3),
        .dcard1(dc1), .dcard2(dc2), .dcard3(dc3),
        .pscore(ps), .dscore(ds),
        .player_tally(pt), .dealer_tally(dt), .tie_tally(tt)
    );

    hand_datapath #(.TALLY_W(2)) dut_small (
        .slow_clock(clk), .reset(rst), .new_card(nc),
        .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
        .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
        .new_round(nr), .player_win_light(pw), .dealer_win_light(dw),
        .pcard1(s_pc1), .pcard2(s_pc2), .pcard3(s_pc3),
        .dcard1(s_dc1), .dcard2(s_dc2), .dcard3(s_dc3),
        .pscore(s_ps), .dscore(s_ds),
        .player_tally(s_pt), .dealer_tally(s_dt), .tie_tally(s_tt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int score(input int a, input int b, input int c);
        return (val(a) + val(b) + val(c)) % 10;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_card[i] = 0;
        m_pt = 0; m_dt = 0; m_tt = 0;
        s_mpt = 0; s_mdt = 0; s_mtt = 0;
        m_prev = 0;
    endtask

    // One rising edge worth of behaviour, from the sampled inputs.
    task automatic model_step();
        int l;
        l = {30'd0, pw, dw};
        if (nr) begin
            for (int i = 0; i < 6; i++) m_card[i] = 0;
        end else begin
            for (int i = 0; i < 6; i++)
                if (ld[i]) m_card[i] = (nc >= 1 && nc <= 13) ? int'(nc) : 0;
        end
        if (m_prev == 0 && l != 0) begin
            if (l == 2) begin if (m_pt < 255) m_pt++; if (s_mpt < 3) s_mpt++; end
            if (l == 1) begin if (m_dt < 255) m_dt++; if (s_mdt < 3) s_mdt++; end
            if (l == 3) begin if (m_tt < 255) m_tt++; if (s_mtt < 3) s_mtt++; end
        end
        m_prev = nr ? 0 : l;
    endtask

    task automatic check_all();
        chk("pcard1", pc1, m_card[0]);
        chk("pcard2", pc2, m_card[1]);
        chk("pcard3", pc3, m_card[2]);
        chk("dcard1", dc1, m_card[3]);
        chk("dcard2", dc2, m_card[4]);
        chk("dcard3", dc3, m_card[5]);
        chk("pscore", ps, score(m_card[0], m_card[1], m_card[2]));
        chk("dscore", ds, score(m_card[3], m_card[4], m_card[5]));
        chk("player_tally", pt, m_pt);
        chk("dealer_tally", dt, m_dt);
        chk("tie_tally", tt, m_tt);
        chk("small_player_tally", {30'd0, s_pt}, s_mpt);
        chk("small_dealer_tally", {30'd0, s_dt}, s_mdt);
        chk("small_tie_tally", {30'd0, s_tt}, s_mtt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic load1(input int idx, input int card);
        nc = 4'(card);
        ld = 6'd0;
        ld[idx] = 1'b1;
        tick();
        ld = 6'd0;
    endtask

    task automatic lights(input logic p, input logic d, input int n);
        pw = p; dw = d;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        #3;
        check_all();                       // reset state while reset held
        @(negedge clk);
        rst = 1'b0;

        // Plan 1: player 9,8 -> 7; dealer K,5 -> 5
        load1(0, 9);
        load1(1, 8);
        chk("plan1_pscore", ps, 7);
        load1(3, 13);
        load1(4, 5);
        chk("plan1_dscore", ds, 5);
        chk("plan1_pcard3", pc3, 0);

        // Plan 2: 7+6+9 = 22 -> 2; invalid card 15 stores 0
        load1(0, 7);
        load1(1, 6);
        load1(2, 9);
        chk("plan2_pscore", ps, 2);
        load1(3, 15);
        chk("plan2_dcard1", dc1, 0);
        chk("plan2_dscore", ds, 5);

        // Plan 3: two strobes share one card; new_round beats a load
        nc = 4'd4; ld = 6'b010001;
        tick();
        chk("plan3_pcard1", pc1, 4);
        chk("plan3_dcard2", dc2, 4);
        nc = 4'd6; ld = 6'b000001; nr = 1'b1;
        tick();
        ld = 6'd0; nr = 1'b0;
        chk("plan3_cleared", {pc1, pc2, pc3, dc1, dc2, dc3}, 0);

        // Plan 4: held lights count once; tie after player
        lights(1'b1, 1'b0, 5);
        chk("plan4_player", pt, 1);
        lights(1'b0, 1'b0, 1);
        lights(1'b1, 1'b1, 2);
        chk("plan4_tie", tt, 1);
        chk("plan4_player_still", pt, 1);

        // Saturation on the 2-bit instance
        for (int r = 0; r < 4; r++) begin
            lights(1'b0, 1'b0, 1);
            lights(1'b1, 1'b0, 2);
        end
        chk("sat_small_player", {30'd0, s_pt}, 3);
        chk("sat_big_player", pt, 5);
        lights(1'b0, 1'b0, 1);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            nc = 4'($urandom_range(0, 15));
            for (int i = 0; i < 6; i++) ld[i] = ($urandom_range(0, 3) == 0);
            nr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                pw = 1'($urandom_range(0, 1));
                dw = 1'($urandom_range(0, 1));
            end
            tick();
        end
        nr = 1'b0; ld = 6'd0; pw = 1'b0; dw = 1'b0;

        // Asynchronous reset between edges with cards and tallies loaded
        load1(0, 9);
        load1(3, 3);
        lights(1'b0, 1'b1, 2);
        lights(1'b0, 1'b0, 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
